// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in, serial-out transmitter.
package piso_pkg;

   // Transmitter FSM: IDLE waits for a word, SHIFT drives bits onto the line.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

   localparam int PISO_WIDTH_DEFAULT = 4;

endpackage : piso_pkg

// File: rtl/piso_tx_if.sv
// Load handshake and serial-line bundle between a word producer and piso_tx.
interface piso_tx_if
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEFAULT
) ();

   logic [WIDTH-1:0] par_in;
   logic             load_valid;
   logic             load_ready;
   logic             shift;
   logic             serial_out;
   logic             frame;
   logic             done;

   // Producer / environment side: supplies words and the shift strobe.
   modport master (
      output par_in,
      output load_valid,
      input  load_ready,
      output shift,
      input  serial_out,
      input  frame,
      input  done
   );

   // Transmitter side.
   modport slave (
      input  par_in,
      input  load_valid,
      output load_ready,
      input  shift,
      output serial_out,
      output frame,
      output done
   );

endinterface : piso_tx_if

// File: rtl/piso_tx_shift_bit_counter.sv
// Modulo-WIDTH bit counter with enable, synchronous active-low clear and a
// last-bit flag.
module shift_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
   input  logic clk,
   input  logic i_clr_n,
   input  logic i_en,
   output logic o_last
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [CW-1:0] r_cnt;

   // Count consumed bits, wrapping to zero after the last one.
   always_ff @(posedge clk) begin
      if (!i_clr_n) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_last = (r_cnt == LAST_CNT);

endmodule : shift_bit_counter

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter, MSB first, one bit per shift strobe.
// A one-word holding buffer (or a direct bypass on the last-bit edge) lets
// consecutive words go out with no gap on the serial line.
module piso_tx
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEFAULT   // must match the interface WIDTH
) (
   input  logic      clk,
   input  logic      reset,      // synchronous, active low
   piso_tx_if.slave  bus
);

   piso_state_t      r_state;
   piso_state_t      w_state_next;

   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_full;
   logic             r_done;

   logic             w_cnt_clr_n;
   logic             w_last;
   logic             w_in_shift;
   logic             w_accept;
   logic             w_consume;
   logic             w_last_consume;
   logic             w_hold_drain;
   logic             w_bypass;
   logic             w_finish;
   logic             w_hold_load;

   logic             w_serial_out;
   logic             w_frame;
   logic             w_load_ready;

   // ------------------------------------------------------------------
   // Event decode
   // ------------------------------------------------------------------
   assign w_in_shift     = (r_state == SHIFT);
   // Ready depends only on the hold flag, so no input reaches load_ready.
   assign w_accept       = bus.load_valid & ~r_hold_full;
   assign w_consume      = w_in_shift & bus.shift;
   assign w_last_consume = w_consume & w_last;
   // Last bit leaves: refill from hold, bypass a fresh word, or finish.
   assign w_hold_drain   = w_last_consume &  r_hold_full;
   assign w_bypass       = w_last_consume & ~r_hold_full &  w_accept;
   assign w_finish       = w_last_consume & ~r_hold_full & ~w_accept;
   // Words accepted mid-word park in hold; a bypass goes straight to sr.
   assign w_hold_load    = w_accept & w_in_shift & ~w_bypass;

   // Counter is held at zero outside SHIFT so every word starts at bit 0.
   assign w_cnt_clr_n    = reset & w_in_shift;

   shift_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk     (clk),
      .i_clr_n (w_cnt_clr_n),
      .i_en    (w_consume),
      .o_last  (w_last)
   );

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: leave IDLE on accept, return only when the line runs dry.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_state_next = SHIFT;
         SHIFT:   if (w_finish) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Output decode, from registers only.
   always_comb begin
      w_serial_out = 1'b0;
      w_frame      = 1'b0;
      w_load_ready = ~r_hold_full;
      if (r_state == SHIFT) begin
         w_serial_out = r_sr[WIDTH-1];
         w_frame      = 1'b1;
      end
   end

   assign bus.serial_out = w_serial_out;
   assign bus.frame      = w_frame;
   assign bus.load_ready = w_load_ready;
   assign bus.done       = r_done;

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   // Shift register: load from IDLE, shift on consume, reload after last bit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sr <= '0;
      end else if (r_state == IDLE) begin
         if (w_accept) begin
            r_sr <= bus.par_in;
         end
      end else if (w_consume) begin
         if (!w_last) begin
            r_sr <= {r_sr[WIDTH-2:0], 1'b0};
         end else if (r_hold_full) begin
            r_sr <= r_hold;
         end else if (w_accept) begin
            r_sr <= bus.par_in;
         end else begin
            r_sr <= '0;
         end
      end
   end

   // Holding buffer: a new load wins over a drain on the same edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else if (w_hold_load) begin
         r_hold      <= bus.par_in;
         r_hold_full <= 1'b1;
      end else if (w_hold_drain) begin
         r_hold_full <= 1'b0;
      end
   end

   // Done pulse: one cycle after the last bit when nothing follows.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_finish;
      end
   end

endmodule : piso_tx
